// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - shared CP0 constants, sequencer state encoding and Cause word builder
// Purpose: register numbers, the Status EXL bit index, ExcCode values, the 3-bit
//          sequencer state enum and a helper that packs the Cause word.
// Ports:   none (package)
package cp0_pkg;

    localparam logic [4:0] CP0_STATUS  = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;
    localparam int         CP0_EXL_BIT = 1;

    localparam logic [31:0] CP0_EXC_VECTOR = 32'h0000_0380;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0A;
    localparam logic [4:0] EXC_OV   = 5'h0C;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_E_EPC    = 3'd1,
        S_E_CAUSE  = 3'd2,
        S_E_STATUS = 3'd3,
        S_E_REDIR  = 3'd4,
        S_R_STATUS = 3'd5,
        S_R_REDIR  = 3'd6
    } state_t;

    // Cause: bit 31 = BD, bits 6:2 = ExcCode, everything else zero.
    function automatic logic [31:0] cause_word(input logic bd, input logic [4:0] code);
        return {bd, 15'b0, 8'b0, 1'b0, code, 2'b0};
    endfunction

endpackage

// File: rtl/cp0_exc_seq.sv
// rtl/cp0_exc_seq.sv - exception/ERET sequencer and CP0 write-port arbiter
// Purpose: serialises the EPC/Cause/Status writes of exception entry, the Status
//          write of ERET, and shares the single CP0 write port with MTC0.
// Ports:   clk/rst (async active-low); exc_*, eret_req, mtc0_* from the pipeline;
//          cp0_rdata/cp0_epc from CP0; cp0_addrR/selR read port; cp0_addrW/selW/
//          din/write write port; stall, redirect, redirect_pc, busy to the pipeline.
module cp0_exc_seq
    import cp0_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR  = CP0_EXC_VECTOR,
    parameter logic [4:0]  STATUS_ADDR = CP0_STATUS,
    parameter logic [4:0]  CAUSE_ADDR  = CP0_CAUSE,
    parameter logic [4:0]  EPC_ADDR    = CP0_EPC,
    parameter int          EXL_BIT     = CP0_EXL_BIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exc_req,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic        exc_bd,
    input  logic        eret_req,
    input  logic        mtc0_req,
    input  logic [4:0]  mtc0_addr,
    input  logic [5:0]  mtc0_sel,
    input  logic [31:0] mtc0_data,
    output logic        mtc0_ack,
    input  logic [31:0] cp0_rdata,
    input  logic [31:0] cp0_epc,
    output logic [4:0]  cp0_addrR,
    output logic [5:0]  cp0_selR,
    output logic [4:0]  cp0_addrW,
    output logic [5:0]  cp0_selW,
    output logic [31:0] cp0_din,
    output logic        cp0_write,
    output logic        stall,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        busy
);

    localparam logic [31:0] EXL_MASK = 32'd1 << EXL_BIT;

    state_t      state_q, state_d;
    logic [4:0]  code_q, code_d;
    logic        bd_q, bd_d;
    logic [31:0] epc_q, epc_d;

    // Request inputs only count while out of reset and idle.
    logic idle_live;
    assign idle_live = rst && (state_q == S_IDLE);

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        bd_d    = bd_q;
        epc_d   = epc_q;
        if (!rst) begin
            state_d = S_IDLE;
            code_d  = 5'd0;
            bd_d    = 1'b0;
            epc_d   = 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (exc_req) begin
                        code_d  = exc_code;
                        bd_d    = exc_bd;
                        // A delay-slot fault restarts at the branch, one word back.
                        epc_d   = exc_bd ? (exc_pc - 32'd4) : exc_pc;
                        state_d = S_E_EPC;
                    end else if (eret_req) begin
                        state_d = S_R_STATUS;
                    end
                end
                S_E_EPC:    state_d = S_E_CAUSE;
                S_E_CAUSE:  state_d = S_E_STATUS;
                S_E_STATUS: state_d = S_E_REDIR;
                S_E_REDIR:  state_d = S_IDLE;
                S_R_STATUS: begin
                    epc_d   = cp0_epc;
                    state_d = S_R_REDIR;
                end
                S_R_REDIR:  state_d = S_IDLE;
                default:    state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Cleared through the _d path while rst is low, so no second async group.
    always_ff @(posedge clk) begin
        code_q <= code_d;
        bd_q   <= bd_d;
        epc_q  <= epc_d;
    end

    always_comb begin
        mtc0_ack    = 1'b0;
        cp0_addrR   = 5'd0;
        cp0_selR    = 6'd0;
        cp0_addrW   = 5'd0;
        cp0_selW    = 6'd0;
        cp0_din     = 32'd0;
        cp0_write   = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        case (state_q)
            S_IDLE: begin
                if (idle_live && mtc0_req && !exc_req && !eret_req) begin
                    cp0_write = 1'b1;
                    cp0_addrW = mtc0_addr;
                    cp0_selW  = mtc0_sel;
                    cp0_din   = mtc0_data;
                    mtc0_ack  = 1'b1;
                end
            end
            S_E_EPC: begin
                cp0_write = 1'b1;
                cp0_addrW = EPC_ADDR;
                cp0_din   = epc_q;
            end
            S_E_CAUSE: begin
                cp0_write = 1'b1;
                cp0_addrW = CAUSE_ADDR;
                cp0_din   = cause_word(bd_q, code_q);
            end
            S_E_STATUS: begin
                // Same-cycle read-modify-write through the combinational read port.
                cp0_addrR = STATUS_ADDR;
                cp0_write = 1'b1;
                cp0_addrW = STATUS_ADDR;
                cp0_din   = cp0_rdata | EXL_MASK;
            end
            S_E_REDIR: begin
                redirect    = 1'b1;
                redirect_pc = EXC_VECTOR;
            end
            S_R_STATUS: begin
                cp0_addrR = STATUS_ADDR;
                cp0_write = 1'b1;
                cp0_addrW = STATUS_ADDR;
                cp0_din   = cp0_rdata & ~EXL_MASK;
            end
            S_R_REDIR: begin
                redirect    = 1'b1;
                redirect_pc = epc_q;
            end
            default: ;
        endcase
    end

    assign busy  = (state_q != S_IDLE);
    assign stall = busy | (idle_live & (exc_req | eret_req));

endmodule

// File: tb/tb_cp0_exc_seq.sv
// tb/tb_cp0_exc_seq.sv - scoreboard bench for the CP0 exception/ERET sequencer
module tb_cp0_exc_seq;

    logic        clk;
    logic        rst;
    logic        exc_req;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        exc_bd;
    logic        eret_req;
    logic        mtc0_req;
    logic [4:0]  mtc0_addr;
    logic [5:0]  mtc0_sel;
    logic [31:0] mtc0_data;
    logic        mtc0_ack;
    logic [31:0] cp0_rdata;
    logic [31:0] cp0_epc;
    logic [4:0]  cp0_addrR;
    logic [5:0]  cp0_selR;
    logic [4:0]  cp0_addrW;
    logic [5:0]  cp0_selW;
    logic [31:0] cp0_din;
    logic        cp0_write;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        busy;

    cp0_exc_seq dut (
        .clk(clk), .rst(rst),
        .exc_req(exc_req), .exc_code(exc_code), .exc_pc(exc_pc), .exc_bd(exc_bd),
        .eret_req(eret_req),
        .mtc0_req(mtc0_req), .mtc0_addr(mtc0_addr), .mtc0_sel(mtc0_sel),
        .mtc0_data(mtc0_data), .mtc0_ack(mtc0_ack),
        .cp0_rdata(cp0_rdata), .cp0_epc(cp0_epc),
        .cp0_addrR(cp0_addrR), .cp0_selR(cp0_selR),
        .cp0_addrW(cp0_addrW), .cp0_selW(cp0_selW),
        .cp0_din(cp0_din), .cp0_write(cp0_write),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        redir;
        logic [4:0]  addr;
        logic [5:0]  sel;
        logic [31:0] data;
        logic        ack;
    } exp_t;

    exp_t q[$];
    int   vec_cnt  = 0;
    int   miss_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_w(input logic [4:0] addr, input logic [5:0] sel,
                          input logic [31:0] data, input logic ack);
        exp_t e;
        e.redir = 1'b0; e.addr = addr; e.sel = sel; e.data = data; e.ack = ack;
        q.push_back(e);
    endtask

    task automatic push_r(input logic [31:0] pc);
        exp_t e;
        e.redir = 1'b1; e.addr = 5'd0; e.sel = 6'd0; e.data = pc; e.ack = 1'b0;
        q.push_back(e);
    endtask

    // Monitor: every write or redirect the DUT presents is matched against the queue.
    always @(negedge clk) begin
        if (rst) begin
            if (cp0_write || redirect) begin
                if (q.size() == 0) begin
                    vec_cnt++;
                    miss_cnt++;
                    $display("FAIL unexpected_output: write=%0b redirect=%0b addrW=%0d din=%h, expected no output (t=%0t)",
                             cp0_write, redirect, cp0_addrW, cp0_din, $time);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("out_kind_redirect", {31'd0, redirect}, {31'd0, e.redir});
                    if (e.redir) begin
                        chk("redirect_pc", redirect_pc, e.data);
                        chk("no_write_on_redirect", {31'd0, cp0_write}, 32'd0);
                    end else begin
                        chk("addrW", {27'd0, cp0_addrW}, {27'd0, e.addr});
                        chk("selW", {26'd0, cp0_selW}, {26'd0, e.sel});
                        chk("din", cp0_din, e.data);
                        chk("mtc0_ack", {31'd0, mtc0_ack}, {31'd0, e.ack});
                    end
                end
            end else begin
                chk("idle_redirect_pc_zero", redirect_pc, 32'd0);
            end
            if (busy) chk("selR_zero_in_seq", {26'd0, cp0_selR}, 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_exc(input logic [4:0] code, input logic [31:0] pc, input logic bd,
                           input logic [31:0] rdata, input logic [31:0] e_epc,
                           input logic [31:0] e_cause, input logic [31:0] e_status);
        cp0_rdata = rdata;
        exc_code  = code;
        exc_pc    = pc;
        exc_bd    = bd;
        exc_req   = 1'b1;
        push_w(5'd14, 6'd0, e_epc, 1'b0);
        push_w(5'd13, 6'd0, e_cause, 1'b0);
        push_w(5'd12, 6'd0, e_status, 1'b0);
        push_r(32'h0000_0380);
        @(negedge clk);
        chk("exc_stall_c0", {31'd0, stall}, 32'd1);
        tick();
        exc_req = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk("exc_stall_seq", {31'd0, stall}, 32'd1);
            chk("exc_busy_seq", {31'd0, busy}, 32'd1);
            tick();
        end
        @(negedge clk);
        chk("exc_busy_done", {31'd0, busy}, 32'd0);
        chk("exc_stall_done", {31'd0, stall}, 32'd0);
        tick();
    endtask

    task automatic run_eret(input logic [31:0] epc, input logic [31:0] rdata,
                            input logic [31:0] e_status);
        cp0_epc   = epc;
        cp0_rdata = rdata;
        eret_req  = 1'b1;
        push_w(5'd12, 6'd0, e_status, 1'b0);
        push_r(epc);
        @(negedge clk);
        chk("eret_stall_c0", {31'd0, stall}, 32'd1);
        tick();
        eret_req = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            chk("eret_busy_seq", {31'd0, busy}, 32'd1);
            tick();
        end
        @(negedge clk);
        chk("eret_busy_done", {31'd0, busy}, 32'd0);
        tick();
    endtask

    task automatic run_mtc0(input logic [4:0] addr, input logic [5:0] sel, input logic [31:0] data);
        mtc0_addr = addr;
        mtc0_sel  = sel;
        mtc0_data = data;
        mtc0_req  = 1'b1;
        push_w(addr, sel, data, 1'b1);
        @(negedge clk);
        chk("mtc0_no_stall", {31'd0, stall}, 32'd0);
        tick();
        mtc0_req = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        exc_req = 1'b0; exc_code = 5'd0; exc_pc = 32'd0; exc_bd = 1'b0;
        eret_req = 1'b0;
        mtc0_req = 1'b0; mtc0_addr = 5'd0; mtc0_sel = 6'd0; mtc0_data = 32'd0;
        cp0_rdata = 32'd0; cp0_epc = 32'd0;
        #1 rst = 1'b0;
        exc_req  = 1'b1;
        mtc0_req = 1'b1; mtc0_addr = 5'd9; mtc0_data = 32'h1234;
        #1;
        chk("rst_write", {31'd0, cp0_write}, 32'd0);
        chk("rst_ack", {31'd0, mtc0_ack}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_din", cp0_din, 32'd0);
        exc_req  = 1'b0;
        mtc0_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        tick();

        // Plain exception and delay-slot exception.
        run_exc(5'h0C, 32'h0040_0100, 1'b0, 32'h0000_FF01,
                32'h0040_0100, 32'h0000_0030, 32'h0000_FF03);
        run_exc(5'h0C, 32'h0000_0000, 1'b1, 32'h0000_FF01,
                32'hFFFF_FFFC, 32'h8000_0030, 32'h0000_FF03);

        run_eret(32'h0040_0104, 32'h0000_FF03, 32'h0000_FF01);

        run_mtc0(5'd9, 6'd0, 32'h0000_1234);
        run_mtc0(5'd16, 6'd1, 32'hA5A5_0001);

        // All three requests together: exception, then ERET, then MTC0.
        cp0_rdata = 32'h0000_FF00;
        cp0_epc   = 32'h0000_1000;
        exc_code  = 5'h04; exc_pc = 32'h0000_1000; exc_bd = 1'b0;
        mtc0_addr = 5'd9; mtc0_sel = 6'd0; mtc0_data = 32'h0000_1234;
        exc_req = 1'b1; eret_req = 1'b1; mtc0_req = 1'b1;
        push_w(5'd14, 6'd0, 32'h0000_1000, 1'b0);
        push_w(5'd13, 6'd0, 32'h0000_0010, 1'b0);
        push_w(5'd12, 6'd0, 32'h0000_FF02, 1'b0);
        push_r(32'h0000_0380);
        push_w(5'd12, 6'd0, 32'h0000_FF00, 1'b0);
        push_r(32'h0000_1000);
        push_w(5'd9, 6'd0, 32'h0000_1234, 1'b1);
        @(negedge clk);
        chk("arb_ack_c0", {31'd0, mtc0_ack}, 32'd0);
        tick();
        exc_req = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        chk("arb_eret_accept_stall", {31'd0, stall}, 32'd1);
        chk("arb_eret_accept_ack", {31'd0, mtc0_ack}, 32'd0);
        tick();
        eret_req = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        chk("arb_mtc0_last_stall", {31'd0, stall}, 32'd0);
        tick();
        mtc0_req = 1'b0;

        // MTC0 arriving mid-sequence is dropped.
        cp0_rdata = 32'h0000_FF01;
        exc_code  = 5'h0A; exc_pc = 32'h0040_0200; exc_bd = 1'b0;
        exc_req   = 1'b1;
        push_w(5'd14, 6'd0, 32'h0040_0200, 1'b0);
        push_w(5'd13, 6'd0, 32'h0000_0028, 1'b0);
        push_w(5'd12, 6'd0, 32'h0000_FF03, 1'b0);
        push_r(32'h0000_0380);
        tick();
        exc_req = 1'b0;
        tick();
        mtc0_req = 1'b1; mtc0_addr = 5'd3; mtc0_sel = 6'd0; mtc0_data = 32'h0000_DEAD;
        @(negedge clk);
        chk("busy_mtc0_ack", {31'd0, mtc0_ack}, 32'd0);
        tick();
        mtc0_req = 1'b0;
        repeat (3) tick();

        // Reset in the middle of E_CAUSE.
        exc_code = 5'h0C; exc_pc = 32'h0040_0300; exc_bd = 1'b0;
        exc_req  = 1'b1;
        push_w(5'd14, 6'd0, 32'h0040_0300, 1'b0);
        tick();
        exc_req = 1'b0;
        tick();
        rst = 1'b0;
        exc_req = 1'b1;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_write", {31'd0, cp0_write}, 32'd0);
        chk("midrst_stall", {31'd0, stall}, 32'd0);
        chk("midrst_redirect", {31'd0, redirect}, 32'd0);
        exc_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (4) tick();

        chk("queue_drained", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

// File: doc/cp0_exc_seq.md
Name: cp0_exc_seq

Overview:
Exception/ERET sequencer and write-port arbiter for the CP0 register file.
- CP0 has one write port and one combinational read port.
- Exception entry needs three CP0 writes (EPC, Cause, Status); this block serialises them, stalls the pipeline, then redirects fetch.
- It also shares the CP0 write port with pipeline MTC0, and sits between the pipeline control and CP0.

Parameters:
EXC_VECTOR, 32'h0000_0380, exception handler PC
STATUS_ADDR, 12, CP0 Status register number
CAUSE_ADDR, 13, CP0 Cause register number
EPC_ADDR, 14, CP0 EPC register number
EXL_BIT, 1, Status bit index of EXL

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
exc_req  in  1  exception raised by pipeline (level)
exc_code  in  5  ExcCode of faulting instruction
exc_pc  in  32  PC of faulting instruction
exc_bd  in  1  faulting instruction is in a delay slot
eret_req  in  1  ERET in commit stage (level)
mtc0_req  in  1  MTC0 write request
mtc0_addr  in  5  MTC0 register number
mtc0_sel  in  6  MTC0 select
mtc0_data  in  32  MTC0 data
mtc0_ack  out  1  MTC0 write performed this cycle
cp0_rdata  in  32  CP0 combinational read data (dout)
cp0_epc  in  32  CP0 EPC output (write-forwarded)
cp0_addrR  out  5  CP0 read address
cp0_selR  out  6  CP0 read select
cp0_addrW  out  5  CP0 write address
cp0_selW  out  6  CP0 write select
cp0_din  out  32  CP0 write data
cp0_write  out  1  CP0 write enable
stall  out  1  freeze pipeline
redirect  out  1  one-cycle fetch redirect pulse
redirect_pc  out  32  redirect target
busy  out  1  FSM not in IDLE

Behaviour:
- FSM states: IDLE, E_EPC, E_CAUSE, E_STATUS, E_REDIR, R_STATUS, R_REDIR. The state register is the only async-reset flop group.
- Reset (rst=0, immediate, any state): state=IDLE. Captured pc/code/bd/epc registers are 0. All outputs are 0, except mtc0 pass-through, which is gated to 0 during reset.
- IDLE request priority: exc_req > eret_req > mtc0_req. The winner is chosen in the same cycle.
- IDLE with exc_req: capture exc_code, exc_bd, and epc_val = exc_bd ? exc_pc-4 : exc_pc (mod 2^32). Next state E_EPC.
- IDLE with eret_req and no exc_req: next state R_STATUS.
- IDLE with only mtc0_req (Mealy pass-through):
  - cp0_write=1; addrW/selW/din = mtc0_addr/mtc0_sel/mtc0_data; mtc0_ack=1.
  - All other states: mtc0_ack=0 and the request is not performed; the pipeline is stalled so it re-presents it.
- E_EPC: write EPC_ADDR, sel 0, din=epc_val.
- E_CAUSE: write CAUSE_ADDR, sel 0, din = {bd,15'b0,8'b0,1'b0,code,2'b0}, i.e. bit31=BD, bits6:2=code, all other bits 0.
- E_STATUS: cp0_addrR=STATUS_ADDR, selR=0. Write STATUS_ADDR with din = cp0_rdata | (1<<EXL_BIT). This is a same-cycle read-modify-write.
- E_REDIR: redirect=1, redirect_pc=EXC_VECTOR, no write. Next state IDLE.
- R_STATUS: read Status, write it back with the EXL bit cleared. Capture cp0_epc into the epc register.
- R_REDIR: redirect=1, redirect_pc = captured epc. Next state IDLE.
- cp0_write is 1 only in E_EPC, E_CAUSE, E_STATUS, R_STATUS, or on an MTC0 grant. Otherwise addrW/selW/din are 0.
- Unused read port: addrR/selR=0.
- stall = busy | (IDLE & (exc_req | eret_req)).
- busy = (state != IDLE).
- redirect_pc=0 when redirect=0.
- Latency: exception accepted at cycle 0 → writes at cycles 1/2/3 → redirect at cycle 4 → IDLE at cycle 5, when the next request can be accepted. ERET: accepted at cycle 0 → Status write at cycle 1 → redirect at cycle 2 → IDLE at cycle 3.
- exc_req/eret_req/mtc0_req are ignored outside IDLE; the sequence always completes.
- A request held high across the return to IDLE is re-accepted.
- Nested exceptions are not special-cased: EPC is overwritten even if EXL=1.

Decomposition:
- Shared package cp0_pkg holds:
  - CP0 register numbers (Status/Cause/EPC);
  - EXL bit index;
  - ExcCode constants;
  - the FSM state enum (3-bit);
  - a function building the Cause word from (bd, code).
- No sub-module: write-port mux and FSM live in one module; output decode is combinational from state.

Test Plan:
- Reset: drive rst=0 mid-E_CAUSE → state IDLE immediately, cp0_write=0, stall=0, redirect=0. Release rst=1 → no spurious writes.
- Exception: exc_req, code=5'h0C, pc=32'h0040_0100, bd=0 → cycle1 write (14,0,0x00400100); cycle2 write (13,0,0x00000030); cycle3 with cp0_rdata=0x0000FF01 write (12,0,0x0000FF03); cycle4 redirect=1, pc=0x380; stall high cycles 0-4.
- Delay slot: bd=1, pc=32'h0000_0000 → EPC din=0xFFFFFFFC, Cause din=0x80000030.
- ERET: cp0_epc=0x00400104, Status read=0x0000FF03 → cycle1 write (12,0,0x0000FF01); cycle2 redirect pc=0x00400104.
- Arbitration: exc_req, eret_req and mtc0_req high together in IDLE → exception sequence runs, mtc0_ack=0. After IDLE, with exc_req low, eret runs next. MTC0 (addr 9, sel 0, data 0x1234) alone → same-cycle write, ack=1.
- Busy drop: mtc0_req pulsed during E_CAUSE → no write, ack=0. selR/selW=0 throughout the sequence.
